// File: rtl/mole_scheduler.sv
// mole_scheduler: whack-a-mole round sequencer. Paces gaps and mole-up windows
// from the timebase tick, picks positions from an LFSR, and keeps score/misses.
module mole_scheduler #(
  parameter int          NUM_MOLES  = 4,
  parameter int          GAP_TICKS  = 40,
  parameter int          UP_TICKS   = 100,
  parameter int          UP_STEP    = 5,
  parameter int          UP_MIN     = 20,
  parameter int          MAX_MISSES = 5,
  parameter int          SCORE_W    = 8,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 start,
  input  logic [NUM_MOLES-1:0] hit_btn,
  output logic [NUM_MOLES-1:0] mole_leds,
  output logic [SCORE_W-1:0]   score,
  output logic [3:0]           misses,
  output logic                 game_over,
  output logic                 busy
);

  localparam int IDX_W   = $clog2(NUM_MOLES);
  localparam int CNT_MAX = (GAP_TICKS > UP_TICKS) ? GAP_TICKS : UP_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int UP_W    = $clog2(UP_TICKS + 1);

  localparam logic [15:0]        LFSR_TAPS  = 16'hB400;
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
  localparam logic [3:0]         MISS_LIMIT = 4'(MAX_MISSES);
  localparam logic [CNT_W-1:0]   GAP_LAST   = CNT_W'(GAP_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GAP,
    S_UP,
    S_OVER
  } state_t;

  // Galois form, shifting right; a nonzero state can never map to zero.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  function automatic logic [IDX_W-1:0] pick_idx(input logic [IDX_W-1:0] raw,
                                                 input logic [IDX_W-1:0] prev);
    return (raw == prev) ? raw + IDX_W'(1) : raw;
  endfunction

  function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
    return (s == SCORE_MAX) ? s : s + SCORE_W'(1);
  endfunction

  function automatic logic [UP_W-1:0] shrink_window(input logic [UP_W-1:0] len);
    if (int'(len) >= UP_MIN + UP_STEP) begin
      return len - UP_W'(UP_STEP);
    end
    return UP_W'(UP_MIN);
  endfunction

  state_t                 state_q,     state_d;
  logic [15:0]            lfsr_q,      lfsr_d;
  logic [UP_W-1:0]        up_len_q,    up_len_d;
  logic [CNT_W-1:0]       tick_cnt_q,  tick_cnt_d;
  logic [IDX_W-1:0]       prev_idx_q,  prev_idx_d;
  logic [NUM_MOLES-1:0]   mole_leds_q, mole_leds_d;
  logic [SCORE_W-1:0]     score_q,     score_d;
  logic [3:0]             misses_q,    misses_d;
  logic                   game_over_q, game_over_d;
  logic                   busy_q,      busy_d;

  logic [IDX_W-1:0] idx_new;
  logic [CNT_W-1:0] up_last;
  logic [3:0]       miss_next;
  logic             hit_ok;
  logic             hit_bad;
  logic             up_done;

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_next(lfsr_q);
    up_len_d    = up_len_q;
    tick_cnt_d  = tick_cnt_q;
    prev_idx_d  = prev_idx_q;
    mole_leds_d = mole_leds_q;
    score_d     = score_q;
    misses_d    = misses_q;

    idx_new   = pick_idx(lfsr_q[IDX_W-1:0], prev_idx_q);
    up_last   = CNT_W'(up_len_q) - CNT_W'(1);
    miss_next = misses_q + 4'd1;
    // mole_leds_q is the lit mask in UP, so it separates right from wrong buttons
    hit_ok    = |(hit_btn & mole_leds_q);
    hit_bad   = |(hit_btn & ~mole_leds_q);
    up_done   = tick && (tick_cnt_q == up_last);

    case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          score_d    = '0;
          misses_d   = '0;
          up_len_d   = UP_W'(UP_TICKS);
          tick_cnt_d = '0;
          state_d    = S_GAP;
        end
      end
      S_GAP: begin
        if (tick) begin
          if (tick_cnt_q == GAP_LAST) begin
            mole_leds_d = NUM_MOLES'(1) << idx_new;
            prev_idx_d  = idx_new;
            tick_cnt_d  = '0;
            state_d     = S_UP;
          end else begin
            tick_cnt_d = tick_cnt_q + CNT_W'(1);
          end
        end
      end
      S_UP: begin
        if (tick) begin
          tick_cnt_d = tick_cnt_q + CNT_W'(1);
        end
        if (hit_ok) begin
          score_d     = score_inc(score_q);
          up_len_d    = shrink_window(up_len_q);
          mole_leds_d = '0;
          tick_cnt_d  = '0;
          state_d     = S_GAP;
        end else if (hit_bad || up_done) begin
          // a wrong press and a timeout together still cost a single miss
          misses_d = miss_next;
          if (miss_next == MISS_LIMIT) begin
            mole_leds_d = '0;
            tick_cnt_d  = '0;
            state_d     = S_OVER;
          end else if (up_done) begin
            mole_leds_d = '0;
            tick_cnt_d  = '0;
            state_d     = S_GAP;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d      = (state_d == S_GAP) || (state_d == S_UP);
    game_over_d = (state_d == S_OVER);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      lfsr_q      <= LFSR_SEED;
      up_len_q    <= UP_W'(UP_TICKS);
      tick_cnt_q  <= '0;
      prev_idx_q  <= '0;
      mole_leds_q <= '0;
      score_q     <= '0;
      misses_q    <= '0;
      game_over_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      up_len_q    <= up_len_d;
      tick_cnt_q  <= tick_cnt_d;
      prev_idx_q  <= prev_idx_d;
      mole_leds_q <= mole_leds_d;
      score_q     <= score_d;
      misses_q    <= misses_d;
      game_over_q <= game_over_d;
      busy_q      <= busy_d;
    end
  end

  assign mole_leds = mole_leds_q;
  assign score     = score_q;
  assign misses    = misses_q;
  assign game_over = game_over_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// tb_mole_scheduler: directed game scenarios against two scheduler instances
// (full-width score and a 2-bit saturating score) sharing the same stimulus.
module tb_mole_scheduler;

  logic       clk_in = 1'b0;
  logic       rst_n  = 1'b0;
  logic       tick   = 1'b0;
  logic       start  = 1'b0;
  logic [3:0] hit_btn = 4'd0;

  logic [3:0] mole_leds, mole_leds_s;
  logic [7:0] score;
  logic [1:0] score_s;
  logic [3:0] misses, misses_s;
  logic       game_over, game_over_s;
  logic       busy, busy_s;

  always #5 clk_in = ~clk_in;

  mole_scheduler #(
    .NUM_MOLES(4), .GAP_TICKS(2), .UP_TICKS(4), .UP_STEP(1), .UP_MIN(2),
    .MAX_MISSES(3), .SCORE_W(8), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .tick(tick), .start(start),
    .hit_btn(hit_btn), .mole_leds(mole_leds), .score(score),
    .misses(misses), .game_over(game_over), .busy(busy)
  );

  mole_scheduler #(
    .NUM_MOLES(4), .GAP_TICKS(2), .UP_TICKS(4), .UP_STEP(1), .UP_MIN(2),
    .MAX_MISSES(3), .SCORE_W(2), .LFSR_SEED(16'hACE1)
  ) dut_sat (
    .clk_in(clk_in), .rst_n(rst_n), .tick(tick), .start(start),
    .hit_btn(hit_btn), .mole_leds(mole_leds_s), .score(score_s),
    .misses(misses_s), .game_over(game_over_s), .busy(busy_s)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic expect_outs(input string tag, input logic lit, input int sc,
                             input int ms, input logic bz, input logic go);
    chk({tag, ".lit"},           32'(mole_leds != 4'd0),   32'(lit));
    chk({tag, ".lit_sat"},       32'(mole_leds_s != 4'd0), 32'(lit));
    chk({tag, ".score"},         32'(score),       sc);
    chk({tag, ".score_sat"},     32'(score_s),     (sc > 3) ? 3 : sc);
    chk({tag, ".misses"},        32'(misses),      ms);
    chk({tag, ".misses_sat"},    32'(misses_s),    ms);
    chk({tag, ".busy"},          32'(busy),        32'(bz));
    chk({tag, ".busy_sat"},      32'(busy_s),      32'(bz));
    chk({tag, ".game_over"},     32'(game_over),   32'(go));
    chk({tag, ".game_over_sat"}, 32'(game_over_s), 32'(go));
  endtask

  // Tick every third cycle; cur_tick tells the caller whether this cycle carried one.
  int   tick_ph  = 0;
  logic cur_tick = 1'b0;

  task automatic cyc(input logic [3:0] btn, input logic st);
    cur_tick = (tick_ph == 2);
    tick_ph  = (tick_ph == 2) ? 0 : tick_ph + 1;
    tick     = cur_tick;
    hit_btn  = btn;
    start    = st;
    @(posedge clk_in);
    #1;
    tick    = 1'b0;
    hit_btn = 4'd0;
    start   = 1'b0;
  endtask

  task automatic wait_lit(output int nt);
    nt = 0;
    for (int i = 0; i < 100 && mole_leds == 4'd0; i++) begin
      cyc(4'd0, 1'b0);
      if (cur_tick) nt++;
    end
    chk("wait_lit_bound", 32'(mole_leds != 4'd0), 1);
  endtask

  task automatic wait_clear(output int nt);
    nt = 0;
    for (int i = 0; i < 100 && mole_leds != 4'd0; i++) begin
      cyc(4'd0, 1'b0);
      if (cur_tick) nt++;
    end
    chk("wait_clear_bound", 32'(mole_leds == 4'd0), 1);
  endtask

  // Reference LFSR: x^16+x^14+x^13+x^11, Galois right-shift; m_prev is the value
  // the DUT saw during the cycle that just ended.
  logic [15:0] m_lfsr, m_prev;
  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr <= 16'hACE1;
      m_prev <= 16'hACE1;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  logic [3:0] mon_last     = 4'd0;
  logic [3:0] mon_last_lit = 4'b0001;
  logic [1:0] mon_pidx     = 2'd0;
  int         appear_cnt   = 0;

  always @(negedge clk_in) begin
    logic [1:0] e;
    if (!rst_n) begin
      mon_last     = 4'd0;
      mon_last_lit = 4'b0001;
      mon_pidx     = 2'd0;
    end else begin
      chk("onehot",     32'((mole_leds & (mole_leds - 4'd1)) == 4'd0), 1);
      chk("onehot_sat", 32'((mole_leds_s & (mole_leds_s - 4'd1)) == 4'd0), 1);
      if (mole_leds != 4'd0 && mon_last == 4'd0) begin
        e = m_prev[1:0];
        if (e == mon_pidx) e = e + 2'd1;
        chk("mole_pos",     32'(mole_leds),   32'(4'b0001 << e));
        chk("mole_pos_sat", 32'(mole_leds_s), 32'(4'b0001 << e));
        chk("no_repeat",    32'(mole_leds & mon_last_lit), 0);
        mon_pidx     = e;
        mon_last_lit = mole_leds;
        appear_cnt++;
      end
      mon_last = mole_leds;
    end
  end

  initial begin
    int         nt;
    logic [3:0] lit;
    logic [3:0] w;

    repeat (3) cyc(4'd0, 1'b0);
    expect_outs("reset", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    repeat (50) begin
      cyc(4'd0, 1'b0);
      expect_outs("idle", 0, 0, 0, 0, 0);
    end

    // Game 1: shrinking windows down to the floor, then three timeouts end it.
    cyc(4'd0, 1'b1);
    expect_outs("g1_start", 0, 0, 0, 1, 0);
    wait_lit(nt); chk("g1_gap1", nt, 2);
    expect_outs("g1_lit1", 1, 0, 0, 1, 0);
    cyc(mole_leds, 1'b0); expect_outs("g1_hit1", 0, 1, 0, 1, 0);
    wait_lit(nt); chk("g1_gap2", nt, 2);
    wait_clear(nt); chk("g1_win3", nt, 3);
    expect_outs("g1_to1", 0, 1, 1, 1, 0);
    wait_lit(nt); cyc(mole_leds, 1'b0); expect_outs("g1_hit2", 0, 2, 1, 1, 0);
    wait_lit(nt); wait_clear(nt); chk("g1_win2a", nt, 2);
    expect_outs("g1_to2", 0, 2, 2, 1, 0);
    wait_lit(nt); cyc(mole_leds, 1'b0); expect_outs("g1_hit3", 0, 3, 2, 1, 0);
    wait_lit(nt); cyc(mole_leds, 1'b0); expect_outs("g1_hit4", 0, 4, 2, 1, 0);
    wait_lit(nt); wait_clear(nt); chk("g1_win2b", nt, 2);
    expect_outs("g1_over", 0, 4, 3, 0, 1);
    repeat (10) begin
      cyc(4'hF, 1'b0);
      expect_outs("over_hold", 0, 4, 3, 0, 1);
    end

    // Game 2: full window, wrong presses, combo press, hit on the timeout tick.
    cyc(4'd0, 1'b1);
    expect_outs("g2_start", 0, 0, 0, 1, 0);
    wait_lit(nt); lit = mole_leds;
    cyc(4'd0, 1'b1);
    chk("g2_start_in_up", 32'(mole_leds), 32'(lit));
    expect_outs("g2_start_ign", 1, 0, 0, 1, 0);
    wait_clear(nt); chk("g2_win4", nt, 4);
    expect_outs("g2_to1", 0, 0, 1, 1, 0);
    wait_lit(nt); lit = mole_leds;
    w = ~lit;
    w = w & (w - 4'd1);
    cyc(w, 1'b0);
    chk("g2_wrong_stays", 32'(mole_leds), 32'(lit));
    expect_outs("g2_wrong", 1, 0, 2, 1, 0);
    w = ~lit;
    w = w & (~w + 4'd1);
    cyc(lit | w, 1'b0);
    expect_outs("g2_combo", 0, 1, 2, 1, 0);
    wait_lit(nt); lit = mole_leds;
    repeat (8) cyc(4'd0, 1'b0);
    chk("g2_still_lit", 32'(mole_leds), 32'(lit));
    cyc(lit, 1'b0);
    expect_outs("g2_hit_at_to", 0, 2, 2, 1, 0);
    wait_lit(nt); wait_clear(nt); chk("g2_win2", nt, 2);
    expect_outs("g2_over", 0, 2, 3, 0, 1);

    // Game 3: a long run of quick hits; narrow score saturates early.
    cyc(4'd0, 1'b1);
    expect_outs("g3_start", 0, 0, 0, 1, 0);
    for (int i = 0; i < 200; i++) begin
      wait_lit(nt);
      cyc(mole_leds, 1'b0);
      if (i == 4) expect_outs("g3_sat5", 0, 5, 0, 1, 0);
    end
    expect_outs("g3_end", 0, 200, 0, 1, 0);
    chk("appearances", appear_cnt, 211);

    // Asynchronous reset in the middle of a mole window.
    cyc(4'd0, 1'b1);
    wait_lit(nt);
    #2 rst_n = 1'b0;
    #1;
    expect_outs("async_rst", 0, 0, 0, 0, 0);
    repeat (2) cyc(4'd0, 1'b0);
    rst_n = 1'b1;
    repeat (5) begin
      cyc(4'd0, 1'b0);
      expect_outs("post_rst", 0, 0, 0, 0, 0);
    end
    cyc(4'd0, 1'b1);
    wait_lit(nt); chk("post_rst_gap", nt, 2);
    cyc(mole_leds, 1'b0);
    expect_outs("post_rst_hit", 0, 1, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mole_scheduler.md
Name: mole_scheduler

Overview:
Game-round controller for the whack-a-mole design. It consumes the 1-cycle timebase tick from the clock divider and sequences mole appearances: a gap, then a mole lit at a pseudo-random position, then a hit or a timeout. It scores hits, counts misses, shortens the mole-up window as the player scores, and ends the game after a fixed number of misses. Its outputs drive the mole LEDs and the score display logic.

Parameters:
NUM_MOLES, 4, number of mole positions; must be a power of two, 2..16
GAP_TICKS, 40, ticks between a mole clearing and the next mole lighting (>=1)
UP_TICKS, 100, initial mole-up window in ticks (>=1)
UP_STEP, 5, ticks removed from the window after each correct hit
UP_MIN, 20, floor of the mole-up window (1..UP_TICKS)
MAX_MISSES, 5, misses that end the game (1..15)
SCORE_W, 8, score width
LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero

Ports:
clk_in  input  1  system clock
rst_n  input  1  asynchronous active-low reset
tick  input  1  timebase pulse, 1 clk_in cycle wide
start  input  1  start pulse, debounced, 1 cycle wide
hit_btn  input  NUM_MOLES  debounced button pulses, one bit per mole
mole_leds  output  NUM_MOLES  one-hot lit mole, or all zero
score  output  SCORE_W  correct hits this game
misses  output  4  misses this game
game_over  output  1  high in OVER state
busy  output  1  high in GAP or UP

Behaviour:
- Reset (async, rst_n=0): state=IDLE; mole_leds=0, score=0, misses=0, game_over=0, busy=0. Internal: lfsr=LFSR_SEED, up_len=UP_TICKS, tick_cnt=0, prev_idx=0.
- All outputs are registered and update on the clk_in edge after the causing input is sampled (1-cycle latency).
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11. It advances every clk_in cycle in every state and never reaches zero.
- States IDLE, GAP, UP, OVER. busy=1 exactly in GAP/UP; game_over=1 exactly in OVER.
- IDLE/OVER + start: score=0, misses=0, up_len=UP_TICKS, tick_cnt=0, game_over=0, next state GAP. In OVER without start, score and misses hold. start is ignored in GAP/UP.
- GAP: mole_leds=0; tick_cnt increments on each tick. On a tick with tick_cnt==GAP_TICKS-1:
  - idx = lfsr[log2(NUM_MOLES)-1:0]; if idx==prev_idx, use idx=(idx+1) mod NUM_MOLES, so the same mole never repeats back-to-back.
  - mole_leds=1<<idx, prev_idx=idx, tick_cnt=0, next state UP.
- UP: tick_cnt increments on each tick. Events are evaluated in the same cycle, in this priority order:
  1. Correct hit (hit_btn[idx]=1, other bits ignored): score+1, saturating at 2^SCORE_W-1; up_len=max(up_len-UP_STEP, UP_MIN), with no underflow; mole_leds=0; tick_cnt=0; next state GAP. A correct hit takes precedence over a timeout in the same cycle.
  2. Wrong hit (any other bit set, correct bit clear): misses+1. At most one miss is counted per cycle, however many wrong bits are set. The mole stays lit and the window continues.
  3. Timeout (tick and tick_cnt==up_len-1): misses+1; mole_leds=0; tick_cnt=0; next state GAP.
  - If a wrong hit and a timeout occur in the same cycle, only one miss is counted, and the timeout transition applies.
- A miss that brings misses to MAX_MISSES sends the block to OVER instead of GAP: mole_leds=0, game_over=1, score frozen.
- hit_btn is ignored in IDLE, GAP and OVER.
- tick is the only time source. Window lengths are exact tick counts and independent of the clk_in/tick ratio.
- Reset asserted mid-game returns the block to the reset values immediately, including the LFSR.

Test Plan:
Bench parameters for all scenarios: NUM_MOLES=4, GAP_TICKS=2, UP_TICKS=4, UP_STEP=1, UP_MIN=2, MAX_MISSES=3; tick every 3 clk_in cycles.
1. Reset then idle for 50 cycles -> mole_leds=0, score=0, misses=0, busy=0, game_over=0 throughout; start pulse -> busy=1 one cycle later, and mole_leds goes one-hot on the 2nd tick.
2. Correct hit_btn pulse while the mole is lit -> score=1 and mole_leds=0 one cycle later; the next window lasts 3 ticks. After 3 more hits, windows last 2, 2, 2 (floor held).
3. No press -> mole clears after exactly 4 ticks, misses=1. After 3 timeouts -> game_over=1, busy=0, mole_leds=0, score held.
4. Wrong button pressed with 2 wrong bits set in one cycle -> misses+1 exactly once, mole stays lit. Correct bit plus a wrong bit in one cycle -> score+1, misses unchanged.
5. Correct hit in the same cycle as the timeout tick -> counted as a hit, misses unchanged. Over 200 mole appearances, no index repeats consecutively; mole_leds always one-hot or zero.
6. rst_n pulsed low mid-UP -> all outputs reset asynchronously. With SCORE_W=2 forced, 5 hits -> score saturates at 3. start in OVER -> score=0, misses=0, play restarts.
